// File: rtl/cmd_bus_arbiter_if.sv
// Requester and command-bus signal bundle for cmd_bus_arbiter.
// The master modport is the arbiter's view; slave is the requesters' and chips' view.
interface cmd_bus_arbiter_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic [DATA_W-1:0]      rd_data;
  logic [NREQ-1:0]        rd_valid;
  logic                   rd_err;
  logic                   busy;
  logic [ADDR_W-1:0]      bus_addr;
  logic [DATA_W-1:0]      bus_data;
  logic                   bus_en;
  logic                   bus_rd;
  logic                   bus_wr;
  logic [DATA_W-1:0]      bus_rd_data;
  logic                   bus_rd_ack;

  modport master (
    input  req, req_wr, req_addr, req_data, bus_rd_data, bus_rd_ack,
    output gnt, rd_data, rd_valid, rd_err, busy, bus_addr, bus_data, bus_en, bus_rd, bus_wr
  );

  modport slave (
    output req, req_wr, req_addr, req_data, bus_rd_data, bus_rd_ack,
    input  gnt, rd_data, rd_valid, rd_err, busy, bus_addr, bus_data, bus_en, bus_rd, bus_wr
  );
endinterface

// File: rtl/cmd_bus_arbiter.sv
// Round-robin owner of the shared command bus: one transaction at a time, read data routed back.
// Define CMD_ARB_RD_TIMEOUT_EN to bound the read-ack wait to RD_TIMEOUT cycles.
module cmd_bus_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  cmd_bus_arbiter_if.master arb
);

  localparam int unsigned OwnW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || RD_TIMEOUT == 0) begin : g_param_check
    $error("cmd_bus_arbiter: NREQ must be 2..8 and RD_TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

  state_e            state_q, state_d;
  logic [OwnW-1:0]   owner_q, owner_d;
  logic [OwnW-1:0]   last_q, last_d;
  logic              wr_q, wr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              bus_en_q, bus_en_d;
  logic              bus_rd_q, bus_rd_d;
  logic              bus_wr_q, bus_wr_d;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];
  logic              pick_found;
  logic [OwnW-1:0]   pick_idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = arb.req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = arb.req_data[i*DATA_W +: DATA_W];
  end

  // First requester found searching upward from the one after the last owner, wrapping.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!pick_found && arb.req[OwnW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = OwnW'(cand);
      end
    end
  end

`ifdef CMD_ARB_RD_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rd_err_q, rd_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign arb.rd_err = rd_err_q;
`else
  assign arb.rd_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wr_d       = wr_q;
    gnt_d      = '0;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    bus_en_d   = 1'b0;
    bus_rd_d   = 1'b0;
    bus_wr_d   = 1'b0;
`ifdef CMD_ARB_RD_TIMEOUT_EN
    cnt_d      = cnt_q;
    rd_err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d    = StIssue;
          owner_d    = pick_idx;
          last_d     = pick_idx;
          wr_d       = arb.req_wr[pick_idx];
          gnt_d      = NREQ'(1) << pick_idx;
          bus_addr_d = addr_arr[pick_idx];
          bus_data_d = data_arr[pick_idx];
          bus_en_d   = 1'b1;
          bus_wr_d   = arb.req_wr[pick_idx];
          bus_rd_d   = ~arb.req_wr[pick_idx];
        end
      end
      StIssue: begin
        state_d = wr_q ? StIdle : StRdWait;
`ifdef CMD_ARB_RD_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StRdWait: begin
        // An ack arriving on the timeout cycle takes priority over the timeout.
        if (arb.bus_rd_ack) begin
          rd_data_d  = arb.bus_rd_data;
          rd_valid_d = NREQ'(1) << owner_q;
          state_d    = StIdle;
        end
`ifdef CMD_ARB_RD_TIMEOUT_EN
        else if (cnt_q == CntW'(RD_TIMEOUT - 1)) begin
          rd_data_d  = DATA_W'(32'hDEADBEEF);
          rd_valid_d = NREQ'(1) << owner_q;
          rd_err_d   = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      last_q     <= OwnW'(NREQ - 1);
      wr_q       <= 1'b0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      bus_en_q   <= 1'b0;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      bus_en_q   <= bus_en_d;
      bus_rd_q   <= bus_rd_d;
      bus_wr_q   <= bus_wr_d;
    end
  end

  assign arb.gnt      = gnt_q;
  assign arb.rd_valid = rd_valid_q;
  assign arb.rd_data  = rd_data_q;
  assign arb.busy     = (state_q != StIdle);
  assign arb.bus_addr = bus_addr_q;
  assign arb.bus_data = bus_data_q;
  assign arb.bus_en   = bus_en_q;
  assign arb.bus_rd   = bus_rd_q;
  assign arb.bus_wr   = bus_wr_q;

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Directed and randomized bench for cmd_bus_arbiter against a transaction-level round-robin model.
// Expectations for the read timeout follow CMD_ARB_RD_TIMEOUT_EN when it is defined.
module tb_cmd_bus_arbiter;
  localparam int unsigned NREQ       = 2;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RD_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  int   model_last;

  always #5 clk = ~clk;

  cmd_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  cmd_bus_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bus_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requesting index after the previous owner, wrapping modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [63:0] onehot(input int i);
    return (i < 0) ? 64'd0 : (64'd1 << i);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus_if.req[i] = 1'b1;
    bus_if.req_wr[i] = wr;
    bus_if.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus_if.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"}, 64'(bus_if.gnt), 64'd0);
    check({tag, ".rd_valid"}, 64'(bus_if.rd_valid), 64'd0);
    check({tag, ".rd_err"}, 64'(bus_if.rd_err), 64'd0);
    check({tag, ".busy"}, 64'(bus_if.busy), 64'd0);
    check({tag, ".bus_en"}, 64'(bus_if.bus_en), 64'd0);
    check({tag, ".bus_rd"}, 64'(bus_if.bus_rd), 64'd0);
    check({tag, ".bus_wr"}, 64'(bus_if.bus_wr), 64'd0);
    check({tag, ".bus_addr"}, 64'(bus_if.bus_addr), 64'd0);
    check({tag, ".bus_data"}, 64'(bus_if.bus_data), 64'd0);
    check({tag, ".rd_data"}, 64'(bus_if.rd_data), 64'd0);
  endtask

  task automatic check_issue(input string tag, input int own, input logic wr,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    check({tag, ".gnt"}, 64'(bus_if.gnt), onehot(own));
    check({tag, ".bus_en"}, 64'(bus_if.bus_en), 64'd1);
    check({tag, ".bus_wr"}, 64'(bus_if.bus_wr), 64'(wr));
    check({tag, ".bus_rd"}, 64'(bus_if.bus_rd), 64'(!wr));
    check({tag, ".bus_addr"}, 64'(bus_if.bus_addr), 64'(a));
    check({tag, ".bus_data"}, 64'(bus_if.bus_data), 64'(d));
    check({tag, ".busy"}, 64'(bus_if.busy), 64'd1);
    check({tag, ".rd_valid"}, 64'(bus_if.rd_valid), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".gnt"}, 64'(bus_if.gnt), 64'd0);
    check({tag, ".bus_en"}, 64'(bus_if.bus_en | bus_if.bus_rd | bus_if.bus_wr), 64'd0);
    check({tag, ".rd_valid"}, 64'(bus_if.rd_valid), 64'd0);
    check({tag, ".rd_err"}, 64'(bus_if.rd_err), 64'd0);
  endtask

  // Single read from one requester; ack arrives lat cycles after the strobe cycle.
  task automatic do_read(input string tag, input int own, input logic [ADDR_W-1:0] a,
                         input int lat, input logic [DATA_W-1:0] dat, input bit junk_ack);
    int w;
    set_req(own, 1'b0, a, ~dat);
    tick();
    w = pick(bus_if.req, model_last);
    check_issue({tag, ".issue"}, w, 1'b0, a, ~dat);
    model_last = w;
    bus_if.req = '0;
    if (junk_ack) begin
      bus_if.bus_rd_ack = 1'b1;
      bus_if.bus_rd_data = dat ^ 32'h0F0F_0F0F;
    end
    for (int c = 1; c < lat; c++) begin
      tick();
      bus_if.bus_rd_ack = 1'b0;
      check_quiet({tag, ".wait"});
      check({tag, ".wait_busy"}, 64'(bus_if.busy), 64'd1);
    end
    tick();
    check_quiet({tag, ".wait"});
    check({tag, ".wait_busy"}, 64'(bus_if.busy), 64'd1);
    bus_if.bus_rd_ack = 1'b1;
    bus_if.bus_rd_data = dat;
    tick();
    bus_if.bus_rd_ack = 1'b0;
    check({tag, ".rd_valid"}, 64'(bus_if.rd_valid), onehot(w));
    check({tag, ".rd_data"}, 64'(bus_if.rd_data), 64'(dat));
    check({tag, ".rd_err"}, 64'(bus_if.rd_err), 64'd0);
    tick();
    check({tag, ".rd_valid_end"}, 64'(bus_if.rd_valid), 64'd0);
    check({tag, ".rd_data_hold"}, 64'(bus_if.rd_data), 64'(dat));
  endtask

  initial begin
    logic [ADDR_W-1:0] a [NREQ];
    logic [DATA_W-1:0] d [NREQ];
    logic [DATA_W-1:0] rdat;
    int w;

    bus_if.req = '0;
    bus_if.req_wr = '0;
    bus_if.req_addr = '0;
    bus_if.req_data = '0;
    bus_if.bus_rd_data = '0;
    bus_if.bus_rd_ack = 1'b0;
    model_last = NREQ - 1;

    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;

    // Single write from requester 0.
    set_req(0, 1'b1, 19'h00012, 32'hA5A5A5A5);
    tick();
    w = pick(bus_if.req, model_last);
    check_issue("wr0", w, 1'b1, 19'h00012, 32'hA5A5A5A5);
    model_last = w;
    bus_if.req = '0;
    tick();
    check_quiet("wr0_done");
    check("wr0_done.busy", 64'(bus_if.busy), 64'd0);
    check("wr0_done.addr_hold", 64'(bus_if.bus_addr), 64'h12);
    check("wr0_done.data_hold", 64'(bus_if.bus_data), 64'hA5A5A5A5);

    // Both requesters hold writes continuously: alternate grants every 2 cycles.
    for (int i = 0; i < NREQ; i++) begin
      a[i] = ADDR_W'($urandom());
      d[i] = $urandom();
      set_req(i, 1'b1, a[i], d[i]);
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      w = pick(bus_if.req, model_last);
      check_issue("rr_wr", w, 1'b1, a[w], d[w]);
      model_last = w;
      a[w] = ADDR_W'($urandom());
      d[w] = $urandom();
      set_req(w, 1'b1, a[w], d[w]);
      tick();
      check_quiet("rr_gap");
      check("rr_gap.busy", 64'(bus_if.busy), 64'd0);
    end
    bus_if.req = '0;
    tick();

    // Ack while idle must be ignored.
    bus_if.bus_rd_ack = 1'b1;
    bus_if.bus_rd_data = 32'hBAD0BAD0;
    tick();
    bus_if.bus_rd_ack = 1'b0;
    check("idle_ack.rd_valid", 64'(bus_if.rd_valid), 64'd0);
    check("idle_ack.busy", 64'(bus_if.busy), 64'd0);

    // Directed read with a spurious ack during the strobe cycle, then random reads.
    do_read("rd1", 1, 19'h00100, 3, 32'h12345678, 1'b1);
    for (int t = 0; t < 4; t++) begin
      do_read("rd_rand", int'($urandom_range(0, NREQ - 1)), ADDR_W'($urandom()),
              int'($urandom_range(1, 5)), $urandom(), 1'b0);
    end

    // Requester 0 arrives while requester 1's read is outstanding.
    set_req(1, 1'b0, 19'h00200, 32'h0);
    tick();
    w = pick(bus_if.req, model_last);
    check_issue("hold_rd", w, 1'b0, 19'h00200, 32'h0);
    model_last = w;
    bus_if.req = '0;
    a[0] = ADDR_W'($urandom());
    d[0] = $urandom();
    rdat = $urandom();
    tick();
    set_req(0, 1'b1, a[0], d[0]);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_wait.gnt", 64'(bus_if.gnt), 64'd0);
      check("hold_wait.busy", 64'(bus_if.busy), 64'd1);
    end
    bus_if.bus_rd_ack = 1'b1;
    bus_if.bus_rd_data = rdat;
    tick();
    bus_if.bus_rd_ack = 1'b0;
    check("hold_ack.rd_valid", 64'(bus_if.rd_valid), onehot(model_last));
    check("hold_ack.rd_data", 64'(bus_if.rd_data), 64'(rdat));
    check("hold_ack.gnt", 64'(bus_if.gnt), 64'd0);
    tick();
    w = pick(bus_if.req, model_last);
    check_issue("hold_gnt", w, 1'b1, a[0], d[0]);
    model_last = w;
    bus_if.req = '0;
    tick();
    check_quiet("hold_done");

    // Read that never gets an ack.
    set_req(1, 1'b0, 19'h00321, 32'h0);
    tick();
    w = pick(bus_if.req, model_last);
    check_issue("to_issue", w, 1'b0, 19'h00321, 32'h0);
    model_last = w;
    bus_if.req = '0;
`ifdef CMD_ARB_RD_TIMEOUT_EN
    for (int c = 0; c < int'(RD_TIMEOUT); c++) begin
      tick();
      check_quiet("to_wait");
      check("to_wait.busy", 64'(bus_if.busy), 64'd1);
    end
    tick();
    check("to.rd_err", 64'(bus_if.rd_err), 64'd1);
    check("to.rd_valid", 64'(bus_if.rd_valid), onehot(w));
    check("to.rd_data", 64'(bus_if.rd_data), 64'hDEADBEEF);
    check("to.busy", 64'(bus_if.busy), 64'd0);
    tick();
    check("to_end.rd_err", 64'(bus_if.rd_err), 64'd0);
    // Start another read so reset lands mid-RD_WAIT.
    set_req(0, 1'b0, 19'h00044, 32'h0);
    tick();
    w = pick(bus_if.req, model_last);
    check_issue("rst_issue", w, 1'b0, 19'h00044, 32'h0);
    model_last = w;
    bus_if.req = '0;
    tick();
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      check_quiet("nto_wait");
      check("nto_wait.busy", 64'(bus_if.busy), 64'd1);
    end
`endif

    // Reset in RD_WAIT: everything clears at once and the late ack is dropped.
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    bus_if.bus_rd_ack = 1'b1;
    bus_if.bus_rd_data = 32'hCAFEF00D;
    model_last = NREQ - 1;
    tick();
    rst = 1'b0;
    tick();
    bus_if.bus_rd_ack = 1'b0;
    check("post_rst.rd_valid", 64'(bus_if.rd_valid), 64'd0);
    check("post_rst.busy", 64'(bus_if.busy), 64'd0);
    check("post_rst.rd_data", 64'(bus_if.rd_data), 64'd0);
    tick();
    check("post_rst2.rd_valid", 64'(bus_if.rd_valid), 64'd0);
    set_req(0, 1'b1, 19'h00077, 32'h11112222);
    set_req(1, 1'b1, 19'h00088, 32'h33334444);
    tick();
    w = pick(bus_if.req, model_last);
    check_issue("post_rst_gnt", w, 1'b1, 19'h00077, 32'h11112222);
    bus_if.req = '0;
    tick();
    check_quiet("post_rst_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
